axi_lite_join_cut: RTL and testbench
====================================

# axi_lite_join_cut

Parametrised AXI-Lite connector joining a slave-side port to a master-side port, with an independently selectable register cut on each of the five channels (AW, W, B, AR, R). Each cut is a two-entry spill register: full throughput, one cycle latency, and no combinational path from either valid or ready across the cut. It sits between crossbar ports and peripherals wherever timing closure needs AXI-Lite paths broken. With all cuts disabled it degenerates to a plain wire-through join.

## Interface
Parameters:
- AddrWidth, 32, AXI-Lite address width; must equal width of `aw.addr`/`ar.addr` in req_t.
- DataWidth, 32, data width; strobe width is DataWidth/8.
- req_t, logic, AXI-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- resp_t, logic, AXI-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).
- CutAw, CutW, CutB, CutAr, CutR, 1'b1 each, 1 = spill register on that channel, 0 = wire bypass.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- slv_req_i  in  req_t  request from upstream master.
- slv_resp_o  out  resp_t  response to upstream master.
- mst_req_o  out  req_t  request to downstream slave.
- mst_resp_i  in  resp_t  response from downstream slave.

## Operation
- Channel direction: AW, W, AR forward slv→mst; B, R forward mst→slv. Payload carried unmodified (addr, prot, data, strb, resp).
- Bypassed channel (Cut*=0): valid, ready and payload wired straight through; no state.
- Cut channel: two slots, A (output) and B (spill).
  - States: EMPTY (A,B empty), HALF (A full), FULL (A,B full).
  - in_ready = !B_full, registered; out_valid = A_full; out_payload = A.
  - EMPTY + in handshake → HALF (load A).
  - HALF + in handshake, no out handshake → FULL (load B).
  - HALF + out handshake, no in handshake → EMPTY.
  - HALF + both handshakes → HALF (A reloaded with new data).
  - FULL + out handshake → HALF (B moves to A); no input accepted since in_ready=0.
- Ordering: strictly FIFO per channel; no reordering, merging or dropping.
- No cross-channel coupling: AW and W proceed independently; the block never waits for AW/W pairing.
- Parameter check: AddrWidth, DataWidth against struct field widths by elaboration-time assertion (simulation only).

## Timing
- Reset (rst_i high at clock edge): every slot empty; all output valids (mst aw/w/ar_valid, slv b/r_valid) 0; all cut-side readies 1 from the first cycle after reset release. Payload registers are not reset (don't-care while valid=0).
- Latency through a cut: 1 cycle (input handshake at edge N → output valid after edge N).
- Throughput: 1 beat/cycle per channel sustained when downstream ready stays high.
- Backpressure: downstream ready low → stores at most 2 beats, then in_ready drops the following cycle; no beat lost.
- Valid must not depend on ready on either side; once asserted, out_valid and payload stay stable until handshake (AXI rule, guaranteed by slot A).
- Reset asserted mid-transfer: contents discarded; the system resets both neighbours together, so no recovery protocol is defined.

## Configuration
- AXI_LITE_JOIN_CUT_STATS_EN defined: adds output ports `stat_wr_o` and `stat_rd_o` (32 bits each). These count completed B and R handshakes on the slave side, wrap modulo 2^32, and reset to 0 with rst_i.
- Not defined: ports and counters absent; no other behavioural difference.

## Test plan
- Reset: hold rst_i 3 cycles with slv aw_valid=1 → all valids 0 during reset; aw_ready=1 in the first cycle after release; first AW appears on mst one cycle after handshake.
- Streaming: 16 back-to-back writes to addr 0x1000+4i, data 0xA5A50000+i, downstream always ready → mst sees identical sequence, one beat/cycle, one-cycle latency; 16 B responses OKAY returned in order.
- Backpressure: mst ar_ready=0 while 5 ARs offered → exactly 2 accepted, slv ar_ready=0 from the third cycle; release → remaining 3 pass in order, no duplicates.
- Simultaneous in/out in HALF: R channel with one beat held, push 0xDEADBEEF while draining → out beat next cycle is 0xDEADBEEF, occupancy remains 1.
- Bypass: all Cut*=0 → zero-latency path; mst_req_o equals slv_req_i combinationally for 100 random cycles.
- Stats (macro defined): 7 writes + 4 reads completed → stat_wr_o=7, stat_rd_o=4; preset counter to 0xFFFFFFFF via force → next B yields 0.

Source files
------------

// File: rtl/axi_lite_join_cut.sv
// AXI-Lite join with an optional two-entry spill-register cut on each of the AW, W, B, AR, R channels.
// Optional feature macro: AXI_LITE_JOIN_CUT_STATS_EN adds slave-side B/R handshake counters (stat_wr_o, stat_rd_o).

package axi_lite_join_cut_pkg;
    typedef struct packed { logic [31:0] addr; logic [2:0] prot; } aw_chan_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_chan_t;
    typedef struct packed { logic [1:0]  resp; } b_chan_t;
    typedef struct packed { logic [31:0] addr; logic [2:0] prot; } ar_chan_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;
endpackage

module axi_lite_join_cut_spill #(
    parameter bit Bypass = 1'b0,
    parameter int Width  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Width-1:0] o_data
);
    if (Bypass) begin : g_bypass
        logic w_unused;
        assign w_unused = clk_i ^ rst_i;
        assign o_valid  = i_valid;
        assign o_ready  = i_ready;
        assign o_data   = i_data;
    end else begin : g_cut
        typedef enum logic [1:0] {EMPTY, HALF, FULL} state_e;

        state_e           r_state;
        state_e           w_nextState;
        logic [Width-1:0] r_slotA;
        logic [Width-1:0] r_slotB;
        logic             w_inHs;
        logic             w_outHs;
        logic             w_loadA;
        logic             w_loadB;
        logic             w_shiftBtoA;

        // Both handshake qualifiers come from the state register only, so no valid/ready path crosses the cut.
        assign o_ready = (r_state != FULL);
        assign o_valid = (r_state != EMPTY);
        assign o_data  = r_slotA;
        assign w_inHs  = i_valid && o_ready;
        assign w_outHs = o_valid && i_ready;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= EMPTY;
            end else begin
                r_state <= w_nextState;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_loadA) begin
                r_slotA <= i_data;
            end else if (w_shiftBtoA) begin
                r_slotA <= r_slotB;
            end
            if (w_loadB) begin
                r_slotB <= i_data;
            end
        end

        always_comb begin
            w_nextState = r_state;
            w_loadA     = 1'b0;
            w_loadB     = 1'b0;
            w_shiftBtoA = 1'b0;
            case (r_state)
                EMPTY: begin
                    if (w_inHs) begin
                        w_loadA     = 1'b1;
                        w_nextState = HALF;
                    end
                end
                HALF: begin
                    if (w_inHs && w_outHs) begin
                        w_loadA = 1'b1;
                    end else if (w_inHs) begin
                        w_loadB     = 1'b1;
                        w_nextState = FULL;
                    end else if (w_outHs) begin
                        w_nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (w_outHs) begin
                        w_shiftBtoA = 1'b1;
                        w_nextState = HALF;
                    end
                end
                default: w_nextState = EMPTY;
            endcase
        end
    end
endmodule

module axi_lite_join_cut #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter type         req_t     = axi_lite_join_cut_pkg::req_t,
    parameter type         resp_t    = axi_lite_join_cut_pkg::resp_t,
    parameter bit          CutAw     = 1'b1,
    parameter bit          CutW      = 1'b1,
    parameter bit          CutB      = 1'b1,
    parameter bit          CutAr     = 1'b1,
    parameter bit          CutR      = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  req_t        slv_req_i,
    output resp_t       slv_resp_o,
    output req_t        mst_req_o,
    input  resp_t       mst_resp_i
`ifdef AXI_LITE_JOIN_CUT_STATS_EN
    ,
    output logic [31:0] stat_wr_o,
    output logic [31:0] stat_rd_o
`endif
);
    localparam int AwW = $bits(slv_req_i.aw);
    localparam int WW  = $bits(slv_req_i.w);
    localparam int BW  = $bits(mst_resp_i.b);
    localparam int ArW = $bits(slv_req_i.ar);
    localparam int RW  = $bits(mst_resp_i.r);

    if ($bits(slv_req_i.aw.addr) != AddrWidth || $bits(slv_req_i.ar.addr) != AddrWidth) begin : g_addrCheck
        $error("axi_lite_join_cut: AddrWidth does not match req_t address fields");
    end
    if ($bits(slv_req_i.w.data) != DataWidth || $bits(slv_req_i.w.strb) != DataWidth / 8) begin : g_dataCheck
        $error("axi_lite_join_cut: DataWidth does not match req_t write data/strobe fields");
    end

    logic [AwW-1:0] w_awData;
    logic [WW-1:0]  w_wData;
    logic [BW-1:0]  w_bData;
    logic [ArW-1:0] w_arData;
    logic [RW-1:0]  w_rData;
    logic w_awValid, w_awReady, w_wValid, w_wReady, w_bValid, w_bReady;
    logic w_arValid, w_arReady, w_rValid, w_rReady;

    axi_lite_join_cut_spill #(.Bypass(!CutAw), .Width(AwW)) i_cutAw (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_valid(slv_req_i.aw_valid), .o_ready(w_awReady), .i_data(slv_req_i.aw),
        .o_valid(w_awValid), .i_ready(mst_resp_i.aw_ready), .o_data(w_awData)
    );
    axi_lite_join_cut_spill #(.Bypass(!CutW), .Width(WW)) i_cutW (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_valid(slv_req_i.w_valid), .o_ready(w_wReady), .i_data(slv_req_i.w),
        .o_valid(w_wValid), .i_ready(mst_resp_i.w_ready), .o_data(w_wData)
    );
    axi_lite_join_cut_spill #(.Bypass(!CutB), .Width(BW)) i_cutB (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_valid(mst_resp_i.b_valid), .o_ready(w_bReady), .i_data(mst_resp_i.b),
        .o_valid(w_bValid), .i_ready(slv_req_i.b_ready), .o_data(w_bData)
    );
    axi_lite_join_cut_spill #(.Bypass(!CutAr), .Width(ArW)) i_cutAr (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_valid(slv_req_i.ar_valid), .o_ready(w_arReady), .i_data(slv_req_i.ar),
        .o_valid(w_arValid), .i_ready(mst_resp_i.ar_ready), .o_data(w_arData)
    );
    axi_lite_join_cut_spill #(.Bypass(!CutR), .Width(RW)) i_cutR (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_valid(mst_resp_i.r_valid), .o_ready(w_rReady), .i_data(mst_resp_i.r),
        .o_valid(w_rValid), .i_ready(slv_req_i.r_ready), .o_data(w_rData)
    );

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = w_awData;
        mst_req_o.aw_valid = w_awValid;
        mst_req_o.w        = w_wData;
        mst_req_o.w_valid  = w_wValid;
        mst_req_o.b_ready  = w_bReady;
        mst_req_o.ar       = w_arData;
        mst_req_o.ar_valid = w_arValid;
        mst_req_o.r_ready  = w_rReady;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = w_awReady;
        slv_resp_o.w_ready  = w_wReady;
        slv_resp_o.b        = w_bData;
        slv_resp_o.b_valid  = w_bValid;
        slv_resp_o.ar_ready = w_arReady;
        slv_resp_o.r        = w_rData;
        slv_resp_o.r_valid  = w_rValid;
    end

`ifdef AXI_LITE_JOIN_CUT_STATS_EN
    logic [31:0] r_statWr;
    logic [31:0] r_statRd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_statWr <= '0;
            r_statRd <= '0;
        end else begin
            if (w_bValid && slv_req_i.b_ready) begin
                r_statWr <= r_statWr + 32'd1;
            end
            if (w_rValid && slv_req_i.r_ready) begin
                r_statRd <= r_statRd + 32'd1;
            end
        end
    end

    assign stat_wr_o = r_statWr;
    assign stat_rd_o = r_statRd;
`endif
endmodule

// File: tb/tb_axi_lite_join_cut.sv
// Randomised bench for axi_lite_join_cut: each cut channel is modelled as a FIFO holding at most two beats;
// a second, fully bypassed instance must pass every signal straight through.
module tb_axi_lite_join_cut;
    import axi_lite_join_cut_pkg::*;

    localparam int NumChan = 5;

    logic  clk = 1'b0;
    logic  rst;
    req_t  slvReq;
    resp_t mstResp;
    req_t  dutMstReq, bypMstReq;
    resp_t dutSlvResp, bypSlvResp;

    int vectorCount = 0;
    int errorCount  = 0;

    string        chanName[NumChan] = '{"aw", "w", "b", "ar", "r"};
    int           chanWidth[NumChan];
    logic [127:0] inData[NumChan];
    bit           inValid[NumChan];
    bit           inAcc[NumChan];
    bit           outReady[NumChan];
    logic [127:0] fifoMem[NumChan][16];
    int           fifoHead[NumChan];
    int           fifoCount[NumChan];
    int           acceptCnt[NumChan];
    int           deliverCnt[NumChan];
    int           bHsCount;
    int           rHsCount;

`ifdef AXI_LITE_JOIN_CUT_STATS_EN
    logic [31:0] statWr, statRd, bypStatWr, bypStatRd;
`endif

    always #5 clk = ~clk;

    axi_lite_join_cut dut (
        .clk_i(clk), .rst_i(rst),
        .slv_req_i(slvReq), .slv_resp_o(dutSlvResp),
        .mst_req_o(dutMstReq), .mst_resp_i(mstResp)
`ifdef AXI_LITE_JOIN_CUT_STATS_EN
        , .stat_wr_o(statWr), .stat_rd_o(statRd)
`endif
    );

    axi_lite_join_cut #(
        .CutAw(1'b0), .CutW(1'b0), .CutB(1'b0), .CutAr(1'b0), .CutR(1'b0)
    ) byp (
        .clk_i(clk), .rst_i(rst),
        .slv_req_i(slvReq), .slv_resp_o(bypSlvResp),
        .mst_req_o(bypMstReq), .mst_resp_i(mstResp)
`ifdef AXI_LITE_JOIN_CUT_STATS_EN
        , .stat_wr_o(bypStatWr), .stat_rd_o(bypStatRd)
`endif
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveBus();
        slvReq.aw         = inData[0][$bits(aw_chan_t)-1:0];
        slvReq.aw_valid   = inValid[0];
        slvReq.w          = inData[1][$bits(w_chan_t)-1:0];
        slvReq.w_valid    = inValid[1];
        slvReq.b_ready    = outReady[2];
        slvReq.ar         = inData[3][$bits(ar_chan_t)-1:0];
        slvReq.ar_valid   = inValid[3];
        slvReq.r_ready    = outReady[4];
        mstResp.aw_ready  = outReady[0];
        mstResp.w_ready   = outReady[1];
        mstResp.b         = inData[2][$bits(b_chan_t)-1:0];
        mstResp.b_valid   = inValid[2];
        mstResp.ar_ready  = outReady[3];
        mstResp.r         = inData[4][$bits(r_chan_t)-1:0];
        mstResp.r_valid   = inValid[4];
    endtask

    // A beat that was offered but not taken is held unchanged, as the AXI source rule demands.
    task automatic applyStimulus(input int validPct, input int readyPct);
        for (int c = 0; c < NumChan; c++) begin
            if (!(inValid[c] && !inAcc[c])) begin
                inValid[c] = (int'($urandom_range(99)) < validPct);
                inData[c]  = {$urandom, $urandom, $urandom, $urandom} & ((128'd1 << chanWidth[c]) - 128'd1);
            end
            outReady[c] = (int'($urandom_range(99)) < readyPct);
        end
        driveBus();
    endtask

    task automatic checkCycle();
        bit           obsInReady[NumChan];
        bit           obsOutValid[NumChan];
        logic [127:0] obsOutData[NumChan];
        obsInReady  = '{dutSlvResp.aw_ready, dutSlvResp.w_ready, dutMstReq.b_ready,
                        dutSlvResp.ar_ready, dutMstReq.r_ready};
        obsOutValid = '{dutMstReq.aw_valid, dutMstReq.w_valid, dutSlvResp.b_valid,
                        dutMstReq.ar_valid, dutSlvResp.r_valid};
        obsOutData  = '{128'(dutMstReq.aw), 128'(dutMstReq.w), 128'(dutSlvResp.b),
                        128'(dutMstReq.ar), 128'(dutSlvResp.r)};
        for (int c = 0; c < NumChan; c++) begin
            checkOutput({chanName[c], "_in_ready"}, 128'(obsInReady[c]), 128'(fifoCount[c] < 2));
            checkOutput({chanName[c], "_out_valid"}, 128'(obsOutValid[c]), 128'(fifoCount[c] > 0));
            if (obsOutValid[c] && outReady[c]) begin
                deliverCnt[c]++;
                if (c == 2) bHsCount++;
                if (c == 4) rHsCount++;
                if (fifoCount[c] > 0) begin
                    checkOutput({chanName[c], "_out_data"}, obsOutData[c], fifoMem[c][fifoHead[c]]);
                    fifoHead[c]  = (fifoHead[c] + 1) % 16;
                    fifoCount[c] = fifoCount[c] - 1;
                end
            end
            inAcc[c] = inValid[c] && obsInReady[c];
            if (inAcc[c]) begin
                acceptCnt[c]++;
                if (fifoCount[c] < 16) begin
                    fifoMem[c][(fifoHead[c] + fifoCount[c]) % 16] = inData[c];
                    fifoCount[c] = fifoCount[c] + 1;
                end
            end
        end
        checkOutput("byp_mst_req", 128'(bypMstReq), 128'(slvReq));
        checkOutput("byp_slv_resp", 128'(bypSlvResp), 128'(mstResp));
    endtask

    // Every phase starts and ends on a falling edge; inputs change there, outputs are sampled 1 time unit later.
    task automatic runCycles(input int n, input int validPct, input int readyPct);
        for (int k = 0; k < n; k++) begin
            applyStimulus(validPct, readyPct);
            #1;
            checkCycle();
            @(negedge clk);
        end
    endtask

    task automatic clearPhaseCounts();
        for (int c = 0; c < NumChan; c++) begin
            acceptCnt[c]  = 0;
            deliverCnt[c] = 0;
        end
    endtask

    initial begin
        chanWidth = '{$bits(aw_chan_t), $bits(w_chan_t), $bits(b_chan_t), $bits(ar_chan_t), $bits(r_chan_t)};
        for (int c = 0; c < NumChan; c++) begin
            inValid[c]   = 1'b0;
            inAcc[c]     = 1'b0;
            outReady[c]  = 1'b0;
            inData[c]    = '0;
            fifoHead[c]  = 0;
            fifoCount[c] = 0;
        end
        bHsCount = 0;
        rHsCount = 0;
        clearPhaseCounts();

        // AW is offered throughout reset; nothing may appear downstream until reset is released.
        rst        = 1'b1;
        inValid[0] = 1'b1;
        inData[0]  = 128'(35'h0_0000_1000 << 3);
        driveBus();
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_valids", 128'({dutMstReq.aw_valid, dutMstReq.w_valid, dutSlvResp.b_valid,
                                            dutMstReq.ar_valid, dutSlvResp.r_valid}), 128'd0);
        end
        rst = 1'b0;

        // Streaming: one beat per cycle in every channel, one cycle of latency.
        runCycles(32, 100, 100);
        for (int c = 0; c < NumChan; c++) begin
            checkOutput({chanName[c], "_stream_accepted"}, 128'(acceptCnt[c]), 128'd32);
            checkOutput({chanName[c], "_stream_delivered"}, 128'(deliverCnt[c]), 128'd31);
        end

        runCycles(4, 0, 100);

        // Backpressure from empty: exactly two beats are absorbed per channel.
        clearPhaseCounts();
        runCycles(6, 100, 0);
        for (int c = 0; c < NumChan; c++) begin
            checkOutput({chanName[c], "_bp_accepted"}, 128'(acceptCnt[c]), 128'd2);
        end

        runCycles(400, 60, 60);
        runCycles(300, 90, 30);
        runCycles(300, 30, 90);
        runCycles(8, 0, 100);

`ifdef AXI_LITE_JOIN_CUT_STATS_EN
        checkOutput("stat_wr", 128'(statWr), 128'(32'(bHsCount)));
        checkOutput("stat_rd", 128'(statRd), 128'(32'(rHsCount)));
        force dut.r_statWr = 32'hFFFF_FFFF;
        force dut.r_statRd = 32'hFFFF_FFFF;
        release dut.r_statWr;
        release dut.r_statRd;
        bHsCount = 0;
        rHsCount = 0;
        runCycles(6, 100, 100);
        checkOutput("stat_wr_wrap", 128'(statWr), 128'(32'hFFFF_FFFF + 32'(bHsCount)));
        checkOutput("stat_rd_wrap", 128'(statRd), 128'(32'hFFFF_FFFF + 32'(rHsCount)));
        runCycles(4, 0, 100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end
endmodule
